rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of each data channel in bits.
REQ-002 SHALL have parameter NUM_IN, default 4, meaning the number of input channels (2..16).
REQ-003 SHALL have parameter SEL_WIDTH, default 2, meaning the width of the index fields; it SHALL equal ceil(log2(NUM_IN)).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  NUM_IN*DATA_WIDTH  meaning the channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port in_valid  input  NUM_IN  meaning channel i presents data.
REQ-008 SHALL have port in_ready  output  NUM_IN  meaning channel i is accepted this cycle.
REQ-009 SHALL have port mode  input  1  meaning 0 = round-robin arbitration, 1 = fixed select.
REQ-010 SHALL have port sel  input  SEL_WIDTH  meaning the channel index used when mode=1.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  meaning the registered selected data.
REQ-012 SHALL have port out_sel  output  SEL_WIDTH  meaning the source channel of out_data.
REQ-013 SHALL have port out_valid  output  1  meaning out_data/out_sel hold an untaken word.
REQ-014 SHALL have port out_ready  input  1  meaning the consumer takes the word this cycle.

Function
REQ-015 SHALL define load_en = !out_valid || out_ready, meaning the output register is free or is draining this cycle.
REQ-016 In mode=0 the grant SHALL go to the first asserted in_valid bit, searching upward from (last_grant+1) mod NUM_IN with wrap-around.
REQ-017 In mode=1 the grant SHALL go to channel sel only if sel < NUM_IN and in_valid[sel]=1; otherwise there SHALL be no grant.
REQ-018 in_ready[i] SHALL be 1 only when load_en=1, a grant exists, and the grant index is i; at most one bit SHALL be set, and it SHALL be combinational.
REQ-019 A transfer on channel i (in_valid[i] && in_ready[i]) SHALL load out_data <= channel i data, out_sel <= i, and out_valid <= 1 at the next edge: latency is one cycle.
REQ-020 When load_en=1 and there is no grant, out_valid SHALL go to 0; out_data and out_sel SHALL hold their values.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold, and all in_ready bits SHALL be 0.
REQ-022 When out_ready=1 and a new grant occur in the same cycle, both SHALL happen: back-to-back throughput is one word per cycle.
REQ-023 last_grant SHALL update to the granted index only on a transfer and only in mode=0; mode=1 transfers SHALL leave it unchanged.
REQ-024 A change of mode or sel SHALL affect only grants from that cycle on; a word already held in the output register SHALL be unaffected.
REQ-025 With NUM_IN not a power of two, indices >= NUM_IN SHALL never be granted, and the round-robin wrap SHALL go from NUM_IN-1 to 0.

Reset
REQ-026 With reset high at an edge: out_valid=0, out_data=0, out_sel=0, last_grant=NUM_IN-1 (so channel 0 has first priority); in_ready SHALL be all 0 while reset is high.
REQ-027 Reset SHALL take priority over any simultaneous transfer; a word in flight SHALL be discarded.

Structure
REQ-028 A shared package SHALL hold the default DATA_WIDTH/NUM_IN constants and the function computing SEL_WIDTH.
REQ-029 The rotating priority search SHALL be a combinational sub-module rr_pick (inputs: request vector, last_grant; outputs: grant_valid, grant_idx); the output register and pointer SHALL stay in the top module.

Verification
REQ-030 Reset, then in_valid=4'b1111 with data 0x1111/0x2222/0x3333/0x4444 and out_ready=1 held -> outputs 0x1111, 0x2222, 0x3333, 0x4444, 0x1111 on consecutive cycles, with out_sel 0,1,2,3,0.
REQ-031 out_valid=1 holding 0x2222, out_ready=0 for 3 cycles -> out_data is stable at 0x2222 and in_ready=0 for all 3 cycles; on release, the next word appears the following cycle.
REQ-032 mode=1, sel=2, in_valid=4'b0011 -> no grant and out_valid falls to 0; then set in_valid[2]=1 with data 0xBEEF -> out_data=0xBEEF, out_sel=2 one cycle later, and last_grant is unchanged.
REQ-033 last_grant=1, in_valid=4'b0001 -> wrap-around grant to channel 0; then in_valid=4'b1001 -> channel 3 is granted next.
REQ-034 Assert reset while out_valid=1 and a transfer is occurring -> next cycle out_valid=0, out_data=0, out_sel=0, and the first grant after reset goes to channel 0.
REQ-035 NUM_IN=3: mode=1 with sel=3 -> never granted; mode=0 with all valid -> grant sequence is 0,1,2,0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and helpers for the round-robin / fixed-select multiplexing arbiter.
// Holds the default channel geometry and the index-width calculation.
package rr_mux_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_IN     = 4;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

    // Width of a channel index; a 2-channel arbiter still needs one bit.
    function automatic int sel_width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Rotating-priority search: picks the first asserted request strictly after
// last_grant, wrapping from NUM_IN-1 back to 0.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int NUM_IN    = DEFAULT_NUM_IN,
    parameter int SEL_WIDTH = sel_width_for(NUM_IN)
) (
    input  logic [NUM_IN-1:0]    req,
    input  logic [SEL_WIDTH-1:0] last_grant,
    output logic                 grant_valid,
    output logic [SEL_WIDTH-1:0] grant_idx
);

    // Scan from the farthest offset down so the nearest hit is the final assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            logic [SEL_WIDTH-1:0] cand;
            cand = SEL_WIDTH'((int'(last_grant) + k) % NUM_IN);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Multiplexing arbiter: selects one of NUM_IN valid/ready channels (round-robin or
// fixed index) into a single registered output word with one-cycle latency.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_IN     = DEFAULT_NUM_IN,
    parameter int SEL_WIDTH  = sel_width_for(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_sel,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic                  load_en;
    logic                  fixed_mode;
    logic                  rr_valid;
    logic [SEL_WIDTH-1:0]  rr_idx;
    logic                  fixed_valid;
    logic                  grant_valid;
    logic [SEL_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  take;
    logic [SEL_WIDTH-1:0]  last_grant;

    assign load_en    = !out_valid || out_ready;
    assign fixed_mode = (mode == MODE_FIXED);

    rr_pick #(
        .NUM_IN    (NUM_IN),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_rr_pick (
        .req         (in_valid),
        .last_grant  (last_grant),
        .grant_valid (rr_valid),
        .grant_idx   (rr_idx)
    );

    // sel may name a channel that does not exist when NUM_IN is not a power of two.
    assign fixed_valid = (int'(sel) < NUM_IN) && in_valid[sel];

    assign grant_valid = fixed_mode ? fixed_valid : rr_valid;
    assign grant_idx   = fixed_mode ? sel         : rr_idx;
    assign take        = load_en && grant_valid && !reset;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_WIDTH'(i)) begin
                grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register stage: loads on a transfer, empties on a free slot with no grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SEL_WIDTH'(NUM_IN - 1);
        end else if (load_en) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                if (!fixed_mode) begin
                    last_grant <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: a 4-channel and a 3-channel instance share stimulus and are
// checked every cycle against a behavioural model, plus directed scenario checks.
module tb_rr_mux_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [1:0]  sel;
    logic        out_ready;
    logic [3:0]  in_valid;
    logic [63:0] in_data;

    logic [3:0]  in_ready4;
    logic [15:0] out_data4;
    logic [1:0]  out_sel4;
    logic        out_valid4;

    logic [2:0]  in_ready3;
    logic [15:0] out_data3;
    logic [1:0]  out_sel3;
    logic        out_valid3;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: index 0 is the 4-channel DUT, index 1 the 3-channel DUT.
    bit          m_valid [2];
    logic [15:0] m_data  [2];
    int          m_sel   [2];
    int          m_ptr   [2];

    localparam logic [63:0] D0 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    always #5 clk = ~clk;

    rr_mux_arbiter #(.DATA_WIDTH(16), .NUM_IN(4), .SEL_WIDTH(2)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data4),
        .out_sel   (out_sel4),
        .out_valid (out_valid4),
        .out_ready (out_ready)
    );

    rr_mux_arbiter #(.DATA_WIDTH(16), .NUM_IN(3), .SEL_WIDTH(2)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data[47:0]),
        .in_valid  (in_valid[2:0]),
        .in_ready  (in_ready3),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Grant rule: fixed index if it exists and is valid, else first valid after ptr.
    function automatic void model_grant(input int n, input bit md, input int s,
                                        input logic [3:0] v, input int ptr,
                                        output bit gv, output int gi);
        gv = 0;
        gi = 0;
        if (md) begin
            if (s < n && v[s]) begin
                gv = 1;
                gi = s;
            end
        end else begin
            for (int off = 1; off <= n; off++) begin
                int c;
                c = (ptr + off) % n;
                if (!gv && v[c]) begin
                    gv = 1;
                    gi = c;
                end
            end
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_data[k]  = '0;
            m_sel[k]   = 0;
            m_ptr[k]   = (k == 0) ? 3 : 2;
        end
    endtask

    // One cycle: drive on the falling edge, check both instances, then advance the model.
    task automatic step(input logic [3:0] v, input logic [63:0] d, input bit md,
                        input logic [1:0] s, input bit ordy, input bit rst);
        bit          gv  [2];
        int          gi  [2];
        bit          le  [2];
        logic [3:0]  er;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        mode      = md;
        sel       = s;
        out_ready = ordy;
        reset     = rst;
        #1;
        for (int k = 0; k < 2; k++) begin
            int n;
            n     = (k == 0) ? 4 : 3;
            le[k] = !m_valid[k] || ordy;
            model_grant(n, md, int'(s), v, m_ptr[k], gv[k], gi[k]);
            er = (!rst && le[k] && gv[k]) ? (4'b0001 << gi[k]) : 4'b0000;
            if (k == 0) begin
                chk("in_ready4", 32'(in_ready4), 32'(er));
                chk("out_valid4", 32'(out_valid4), 32'(m_valid[0]));
                chk("out_data4", 32'(out_data4), 32'(m_data[0]));
                chk("out_sel4", 32'(out_sel4), 32'(m_sel[0]));
            end else begin
                chk("in_ready3", 32'(in_ready3), 32'(er));
                chk("out_valid3", 32'(out_valid3), 32'(m_valid[1]));
                chk("out_data3", 32'(out_data3), 32'(m_data[1]));
                chk("out_sel3", 32'(out_sel3), 32'(m_sel[1]));
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (le[k]) begin
                    if (gv[k]) begin
                        m_valid[k] = 1;
                        m_data[k]  = d[gi[k]*16 +: 16];
                        m_sel[k]   = gi[k];
                        if (!md) m_ptr[k] = gi[k];
                    end else begin
                        m_valid[k] = 0;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [15:0] exp_rr [5];
        int          exp_s3 [4];
        logic [63:0] d_beef;
        exp_rr = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
        exp_s3 = '{0, 1, 2, 0};
        d_beef = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
        in_valid = '0; in_data = '0; mode = 0; sel = '0; out_ready = 1; reset = 1;
        model_reset();

        step(4'h0, D0, 0, 2'd0, 1, 1);
        step(4'h0, D0, 0, 2'd0, 1, 1);
        chk("reset_valid", 32'(out_valid4), 32'd0);
        chk("reset_data", 32'(out_data4), 32'd0);

        // Round-robin over all four channels; the 3-channel instance wraps 0,1,2,0.
        for (int i = 0; i < 5; i++) begin
            step(4'hF, D0, 0, 2'd0, 1, 0);
            chk("rr_data", 32'(out_data4), 32'(exp_rr[i]));
            chk("rr_sel", 32'(out_sel4), 32'(i % 4));
            if (i < 4) chk("rr3_sel", 32'(out_sel3), 32'(exp_s3[i]));
        end

        // Backpressure: hold 0x2222 for three cycles, then release.
        step(4'hF, D0, 0, 2'd0, 1, 0);
        chk("bp_load", 32'(out_data4), 32'h2222);
        for (int i = 0; i < 3; i++) begin
            step(4'hF, D0, 0, 2'd0, 0, 0);
            chk("bp_hold", 32'(out_data4), 32'h2222);
            chk("bp_ready", 32'(in_ready4), 32'd0);
        end
        step(4'hF, D0, 0, 2'd0, 1, 0);
        chk("bp_release", 32'(out_data4), 32'h3333);

        // Fixed select: absent channel empties the output, then BEEF on channel 2.
        step(4'b0011, D0, 1, 2'd2, 1, 0);
        chk("fix_nogrant", 32'(out_valid4), 32'd0);
        step(4'b0111, d_beef, 1, 2'd2, 1, 0);
        chk("fix_data", 32'(out_data4), 32'hBEEF);
        chk("fix_sel", 32'(out_sel4), 32'd2);
        step(4'b0111, D0, 1, 2'd0, 1, 0);
        step(4'hF, D0, 0, 2'd0, 1, 0);
        chk("fix_ptr_kept", 32'(out_sel4), 32'd3);

        // Wrap-around from last_grant=1.
        step(4'b0010, D0, 0, 2'd0, 1, 0);
        step(4'b0001, D0, 0, 2'd0, 1, 0);
        chk("wrap_to0", 32'(out_sel4), 32'd0);
        step(4'b1001, D0, 0, 2'd0, 1, 0);
        chk("wrap_to3", 32'(out_sel4), 32'd3);

        // Reset wins over a transfer in flight.
        step(4'hF, D0, 0, 2'd0, 1, 1);
        chk("rst_valid", 32'(out_valid4), 32'd0);
        chk("rst_data", 32'(out_data4), 32'd0);
        chk("rst_sel", 32'(out_sel4), 32'd0);
        step(4'hF, D0, 0, 2'd0, 1, 0);
        chk("rst_first", 32'(out_sel4), 32'd0);

        // Nonexistent channel 3 on the 3-channel instance is never granted.
        for (int i = 0; i < 2; i++) begin
            step(4'hF, D0, 1, 2'd3, 1, 0);
            chk("n3_sel3", 32'(out_valid3), 32'd0);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) == 0),
                 2'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
